pin_matrix: RTL and testbench

Runtime-programmable pin routing matrix. It replaces fixed wiring of peripheral function signals (step motor phases, brush motor H-bridge, sensor lines) to PIO header pins. A host config port writes a per-pin shadow table. A commit applies the table to the pads with break-before-make, so pins that are being re-routed never glitch between functions. Pad inputs are synchronised and returned to the peripherals.

---
 rtl/pin_matrix_pkg.sv | 17 +
 rtl/pin_matrix_sync.sv | 28 ++
 rtl/pin_matrix.sv | 184 ++++++++++++++++++
 tb/tb_pin_matrix.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pin_matrix_pkg.sv
// Shared encodings for the pin routing matrix: pad modes, commit FSM states
// and the layout of a config word {mode, sel}.
package pin_matrix_pkg;

    localparam logic [1:0] MODE_HIZ   = 2'd0;
    localparam logic [1:0] MODE_ROUTE = 2'd1;
    localparam logic [1:0] MODE_LOW   = 2'd2;
    localparam logic [1:0] MODE_HIGH  = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BREAK = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

    localparam int CFG_SEL_LSB = 0;
    localparam int CFG_MODE_W  = 2;

endpackage

// File: rtl/pin_matrix_sync.sv
// Two-flop synchroniser for the raw pad inputs; both stages clear on reset.
module pin_matrix_sync #(
    parameter int WIDTH = 26
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so both stages sample
    // their inputs from before the edge and the chain really is two flops deep.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pin_matrix.sv
// Runtime pin routing matrix: host-written shadow table, break-before-make
// commit FSM, registered pad drivers and synchronised pad inputs.
module pin_matrix
    import pin_matrix_pkg::*;
#(
    parameter int NUM_PINS   = 26,
    parameter int NUM_SRC    = 32,
    parameter int SEL_W      = 6,
    parameter int BBM_CYCLES = 4,
    parameter int AW         = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_SRC-1:0]    func_out,
    input  logic [NUM_PINS-1:0]   pin_in,
    output logic [NUM_PINS-1:0]   pin_out,
    output logic [NUM_PINS-1:0]   pin_oe,
    output logic [NUM_PINS-1:0]   pin_in_sync,
    input  logic                  cfg_wr,
    input  logic                  cfg_rd,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [SEL_W+1:0]      cfg_wdata,
    output logic [SEL_W+1:0]      cfg_rdata,
    output logic                  cfg_rvalid,
    output logic                  cfg_err,
    input  logic                  cfg_commit,
    output logic                  busy,
    output logic                  commit_done
);

    localparam int CW      = SEL_W + CFG_MODE_W;
    localparam int SRC_EXT = 2 ** SEL_W;
    localparam int CNT_W   = (BBM_CYCLES > 1) ? $clog2(BBM_CYCLES) : 1;
    localparam logic [AW:0]      PIN_LIMIT = (AW + 1)'(NUM_PINS);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(BBM_CYCLES - 1);

    logic [CW-1:0]       shadow_q [NUM_PINS];
    logic [CW-1:0]       active_q [NUM_PINS];
    logic [CW-1:0]       snap_q   [NUM_PINS];
    logic [NUM_PINS-1:0] diff_d, diff_q;
    logic [1:0]          state_d, state_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic                pending_d, pending_q;
    logic                capture, apply;
    logic                addr_ok;
    logic [CW-1:0]       rdata_q;
    logic                rvalid_q, err_q;
    logic [NUM_PINS-1:0] oe_d, oe_q, out_d, out_q;
    logic [SRC_EXT-1:0]  src_ext;

    // Zero-extending the sources makes any select beyond NUM_SRC read back 0.
    assign src_ext = SRC_EXT'(func_out);
    assign addr_ok = ({1'b0, cfg_addr} < PIN_LIMIT);

    function automatic logic [1:0] pad_drive(input logic [CW-1:0] cfg, input logic [SRC_EXT-1:0] src);
        logic [SEL_W-1:0] sel;
        sel = cfg[CFG_SEL_LSB +: SEL_W];
        case (cfg[SEL_W +: CFG_MODE_W])
            MODE_HIZ:   return 2'b00;
            MODE_ROUTE: return {1'b1, src[sel]};
            MODE_LOW:   return 2'b10;
            MODE_HIGH:  return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    // NOTE: the config tables are small flop arrays, so they take the async reset
    // like any other state; that is what guarantees hi-Z pads out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PINS; i++) shadow_q[i] <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (cfg_wr && addr_ok) shadow_q[cfg_addr] <= cfg_wdata;
            if (cfg_rd) rdata_q <= addr_ok ? shadow_q[cfg_addr] : '0;
            rvalid_q <= cfg_rd;
            err_q    <= (cfg_wr || cfg_rd) && !addr_ok;
        end
    end

    always_comb begin
        diff_d = '0;
        for (int i = 0; i < NUM_PINS; i++) diff_d[i] = (shadow_q[i] != active_q[i]);
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves
        // it unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        capture   = 1'b0;
        apply     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_commit || pending_q) begin
                    capture   = 1'b1;
                    pending_d = 1'b0;
                    if (diff_d != '0) begin
                        state_d = ST_BREAK;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_APPLY;
                    end
                end
            end
            ST_BREAK: begin
                if (cfg_commit) pending_d = 1'b1;
                if (cnt_q == '0) state_d = ST_APPLY;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_APPLY: begin
                if (cfg_commit) pending_d = 1'b1;
                apply   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            diff_q    <= '0;
            for (int i = 0; i < NUM_PINS; i++) begin
                active_q[i] <= '0;
                snap_q[i]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            if (capture) begin
                diff_q <= diff_d;
                for (int i = 0; i < NUM_PINS; i++) snap_q[i] <= shadow_q[i];
            end
            if (apply) begin
                for (int i = 0; i < NUM_PINS; i++) active_q[i] <= snap_q[i];
            end
        end
    end

    // During APPLY the pads already take the snapshot so the new route lands
    // on the same edge that active is updated.
    always_comb begin
        oe_d  = '0;
        out_d = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            if (!(state_q == ST_BREAK && diff_q[i])) begin
                {oe_d[i], out_d[i]} = pad_drive((state_q == ST_APPLY) ? snap_q[i] : active_q[i], src_ext);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            oe_q  <= '0;
            out_q <= '0;
        end else begin
            oe_q  <= oe_d;
            out_q <= out_d;
        end
    end

    pin_matrix_sync #(.WIDTH(NUM_PINS)) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d_i     (pin_in),
        .q_o     (pin_in_sync)
    );

    assign pin_oe      = oe_q;
    assign pin_out     = out_q;
    assign cfg_rdata   = rdata_q;
    assign cfg_rvalid  = rvalid_q;
    assign cfg_err     = err_q;
    assign busy        = (state_q != ST_IDLE);
    assign commit_done = (state_q == ST_APPLY);

endmodule

// File: tb/tb_pin_matrix.sv
// Scoreboard bench for pin_matrix: a timeline model predicts every cycle's pads,
// reads and commit_done pulses; a separate monitor compares what the DUT shows.
module tb_pin_matrix;

    localparam int NP  = 26;
    localparam int NS  = 32;
    localparam int SW  = 6;
    localparam int BBM = 4;
    localparam int AWD = 5;
    localparam int CW  = SW + 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [NS-1:0] func_out = '0;
    logic [NP-1:0] pin_in = '0;
    logic [NP-1:0] pin_out, pin_oe, pin_in_sync;
    logic          cfg_wr = 1'b0, cfg_rd = 1'b0, cfg_commit = 1'b0;
    logic [AWD-1:0] cfg_addr = '0;
    logic [CW-1:0] cfg_wdata = '0;
    logic [CW-1:0] cfg_rdata;
    logic          cfg_rvalid, cfg_err, busy, commit_done;

    pin_matrix #(
        .NUM_PINS(NP), .NUM_SRC(NS), .SEL_W(SW), .BBM_CYCLES(BBM), .AW(AWD)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .func_out    (func_out),
        .pin_in      (pin_in),
        .pin_out     (pin_out),
        .pin_oe      (pin_oe),
        .pin_in_sync (pin_in_sync),
        .cfg_wr      (cfg_wr),
        .cfg_rd      (cfg_rd),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_rdata   (cfg_rdata),
        .cfg_rvalid  (cfg_rvalid),
        .cfg_err     (cfg_err),
        .cfg_commit  (cfg_commit),
        .busy        (busy),
        .commit_done (commit_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            e;
        logic [NP-1:0] oe;
        logic [NP-1:0] out;
        logic [NP-1:0] sync;
        logic          busy;
        logic          err;
    } cyc_exp_t;

    typedef struct {
        int            e;
        logic [CW-1:0] data;
    } rd_exp_t;

    cyc_exp_t cyc_q[$];
    rd_exp_t  rd_q[$];
    int       done_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;
    bit mon_en   = 1'b0;

    // Model: tables as plain ints, plus the in-flight commit as an edge timeline.
    int            m_shadow [NP];
    int            m_active [NP];
    int            m_snap   [NP];
    bit            m_changed[NP];
    bit            m_busy;
    bit            m_pending;
    int            m_apply_edge;
    logic [NP-1:0] m_prev_in;

    always @(posedge clock) edge_no <= edge_no + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_no, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_pad(input int cfg, input logic [NS-1:0] fo);
        int mode;
        int sel;
        mode = (cfg >> SW) & 3;
        sel  = cfg & ((1 << SW) - 1);
        case (mode)
            1:       return {1'b1, (sel < NS) ? 1'(fo >> sel) : 1'b0};
            2:       return 2'b10;
            3:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_shadow[i]  = 0;
            m_active[i]  = 0;
            m_snap[i]    = 0;
            m_changed[i] = 1'b0;
        end
        m_busy       = 1'b0;
        m_pending    = 1'b0;
        m_apply_edge = 0;
        m_prev_in    = '0;
        cyc_q.delete();
        rd_q.delete();
        done_q.delete();
    endtask

    // Predicts everything the DUT shows in the cycle after edge e.
    task automatic model_edge(input int e, input logic c, input logic w, input logic r,
                              input int a, input int d);
        cyc_exp_t   x;
        rd_exp_t    y;
        logic [1:0] p;
        int         cfg;
        bit         masked;
        bit         any;
        x.e   = e;
        x.oe  = '0;
        x.out = '0;
        for (int i = 0; i < NP; i++) begin
            cfg    = m_active[i];
            masked = 1'b0;
            if (m_busy) begin
                if (e == m_apply_edge) cfg = m_snap[i];
                else if (m_changed[i]) masked = 1'b1;
            end
            if (!masked) begin
                p        = ref_pad(cfg, func_out);
                x.oe[i]  = p[1];
                x.out[i] = p[0];
            end
        end
        if (m_busy) begin
            if (c) m_pending = 1'b1;
            if (e == m_apply_edge) begin
                m_active = m_snap;
                m_busy   = 1'b0;
            end
        end else if (c || m_pending) begin
            any       = 1'b0;
            m_pending = 1'b0;
            for (int i = 0; i < NP; i++) begin
                m_snap[i]    = m_shadow[i];
                m_changed[i] = (m_shadow[i] != m_active[i]);
                any          = any | m_changed[i];
            end
            m_apply_edge = e + (any ? BBM + 1 : 1);
            m_busy       = 1'b1;
            done_q.push_back(m_apply_edge - 1);
        end
        x.busy = m_busy;
        x.err  = (w || r) && (a >= NP);
        if (r) begin
            y.e    = e;
            y.data = (a < NP) ? CW'(m_shadow[a]) : '0;
            rd_q.push_back(y);
        end
        if (w && a < NP) m_shadow[a] = d;
        x.sync    = m_prev_in;
        m_prev_in = pin_in;
        cyc_q.push_back(x);
    endtask

    // Called and returns at a falling edge; the next rising edge samples these inputs.
    task automatic drive(input logic c, input logic w, input logic r, input int a, input int d);
        cfg_commit = c;
        cfg_wr     = w;
        cfg_rd     = r;
        cfg_addr   = AWD'(a);
        cfg_wdata  = CW'(d);
        func_out   = $urandom;
        pin_in     = NP'($urandom);
        model_edge(edge_no + 1, c, w, r, a, d);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_pin_oe", pin_oe, '0);
        check("rst_pin_out", pin_out, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_commit_done", commit_done, 1'b0);
        check("rst_rvalid", cfg_rvalid, 1'b0);
        check("rst_err", cfg_err, 1'b0);
        check("rst_sync", pin_in_sync, '0);
        cfg_commit = 1'b0;
        cfg_wr     = 1'b0;
        cfg_rd     = 1'b0;
        @(negedge clock);
        @(negedge clock);
        model_reset();
        reset_n = 1'b1;
        mon_en  = 1'b1;
    endtask

    initial begin : monitor
        cyc_exp_t x;
        rd_exp_t  r;
        forever begin
            @(posedge clock);
            #1;
            if (mon_en) begin
                check("sb_edge", (cyc_q.size() > 0) ? cyc_q[0].e : -1, edge_no);
                if (cyc_q.size() > 0) begin
                    x = cyc_q.pop_front();
                    check("pin_oe", pin_oe, x.oe);
                    check("pin_out", pin_out, x.out);
                    check("pin_in_sync", pin_in_sync, x.sync);
                    check("busy", busy, x.busy);
                    check("cfg_err", cfg_err, x.err);
                end
                if (rd_q.size() > 0 && rd_q[0].e == edge_no) begin
                    r = rd_q.pop_front();
                    check("cfg_rvalid", cfg_rvalid, 1'b1);
                    check("cfg_rdata", cfg_rdata, r.data);
                end else begin
                    check("cfg_rvalid_idle", cfg_rvalid, 1'b0);
                end
                if (done_q.size() > 0 && done_q[0] == edge_no) begin
                    void'(done_q.pop_front());
                    check("commit_done", commit_done, 1'b1);
                end else begin
                    check("commit_done_idle", commit_done, 1'b0);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        model_reset();
        @(negedge clock);
        do_reset();
        idle(10);

        // Route pin 6 to source 0 through a full break-before-make commit.
        drive(1'b0, 1'b1, 1'b0, 6, 8'h40);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        idle(8);

        // Drive pin 8 high, then re-route pin 6 to source 2 while pin 8 stays put.
        drive(1'b0, 1'b1, 1'b0, 8, 8'hC0);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        idle(8);
        drive(1'b0, 1'b1, 1'b0, 6, 8'h42);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        idle(8);

        // Commit with nothing changed.
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        idle(4);

        // Second commit plus a pin 7 write issued during BREAK.
        drive(1'b0, 1'b1, 1'b0, 5, 8'h80);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 7, 8'hC0);
        idle(15);

        // Out-of-range access, read-back, and same-cycle read/write.
        drive(1'b0, 1'b1, 1'b0, 26, 8'hC0);
        drive(1'b0, 1'b0, 1'b1, 26, 0);
        drive(1'b0, 1'b0, 1'b1, 31, 0);
        drive(1'b0, 1'b0, 1'b1, 6, 0);
        drive(1'b0, 1'b1, 1'b1, 6, 8'h43);
        drive(1'b0, 1'b0, 1'b1, 6, 0);

        // Select beyond the last source drives 0 with oe=1.
        drive(1'b0, 1'b1, 1'b0, 3, 8'h68);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        idle(8);

        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 31), $urandom_range(0, 255));
        end
        idle(25);

        // Reset asserted in the middle of BREAK.
        drive(1'b0, 1'b1, 1'b0, 10, m_active[10] ^ 8'h80);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        idle(2);
        check("busy_in_break", busy, 1'b1);
        do_reset();
        idle(6);

        check("rd_q_drained", rd_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
